trace_sequencer: RTL and testbench

//  Parametrised, synthesizable trace-record sequencer feeding the LLC cache_controller.

---
 rtl/trace_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_trace_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_sequencer.sv
// Trace-record sequencer: buffers (cmd, addr, last) records and issues bus commands to the LLC
// controller, decodes clear/print control records into pulses and flags end-of-trace.
module trace_sequencer #(
    parameter int unsigned CMD_W  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned GAP    = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CMD_W-1:0]  out_cmd,
    output logic [ADDR_W-1:0] out_addr,
    output logic              clear_pls,
    output logic              print_pls,
    output logic              eof,
    input  logic              restart,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned ENT_W  = 1 + CMD_W + ADDR_W;
    localparam int unsigned GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_CW-1:0] GAP_LOAD  = GAP_CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CMD_W-1:0]  CMD_BUS_MAX = CMD_W'(6);
    localparam logic [CMD_W-1:0]  CMD_CLEAR   = CMD_W'(8);
    localparam logic [CMD_W-1:0]  CMD_PRINT   = CMD_W'(9);

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StDone} state_t;

    state_t              r_state;
    logic [ENT_W-1:0]    r_mem [DEPTH];
    logic [PTR_W:0]      r_wptr;
    logic [PTR_W:0]      r_rptr;
    logic                r_last_seen;
    logic                r_cur_last;
    logic [GAP_CW-1:0]   r_gap_cnt;
    logic                r_out_valid;
    logic [CMD_W-1:0]    r_out_cmd;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_clear_pls;
    logic                r_print_pls;
    logic                r_eof;
    logic [CNT_W-1:0]    r_issued_cnt;
    logic [CNT_W-1:0]    r_err_cnt;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [ENT_W-1:0]    w_head;
    logic                w_head_last;
    logic [CMD_W-1:0]    w_head_cmd;
    logic [ADDR_W-1:0]   w_head_addr;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    // in_ready comes only from registered state, so a same-cycle pop never frees a slot early.
    assign in_ready = !w_full && !r_last_seen && (r_state != StDone);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == StIdle) && !w_empty;

    assign w_head      = r_mem[r_rptr[PTR_W-1:0]];
    assign w_head_last = w_head[ENT_W-1];
    assign w_head_cmd  = w_head[ADDR_W +: CMD_W];
    assign w_head_addr = w_head[ADDR_W-1:0];

    assign out_valid  = r_out_valid;
    assign out_cmd    = r_out_cmd;
    assign out_addr   = r_out_addr;
    assign clear_pls  = r_clear_pls;
    assign print_pls  = r_print_pls;
    assign eof        = r_eof;
    assign issued_cnt = r_issued_cnt;
    assign err_cnt    = r_err_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[PTR_W-1:0]] <= {in_last, in_cmd, in_addr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_last_seen  <= 1'b0;
            r_cur_last   <= 1'b0;
            r_gap_cnt    <= '0;
            r_out_valid  <= 1'b0;
            r_out_cmd    <= '0;
            r_out_addr   <= '0;
            r_clear_pls  <= 1'b0;
            r_print_pls  <= 1'b0;
            r_eof        <= 1'b0;
            r_issued_cnt <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_clear_pls <= 1'b0;
            r_print_pls <= 1'b0;
            if (w_push && in_last) r_last_seen <= 1'b1;
            unique case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        if (w_head_cmd <= CMD_BUS_MAX) begin
                            r_out_valid <= 1'b1;
                            r_out_cmd   <= w_head_cmd;
                            r_out_addr  <= w_head_addr;
                            r_cur_last  <= w_head_last;
                            r_state     <= StIssue;
                        end else if (w_head_cmd == CMD_CLEAR || w_head_cmd == CMD_PRINT) begin
                            r_clear_pls <= (w_head_cmd == CMD_CLEAR);
                            r_print_pls <= (w_head_cmd == CMD_PRINT);
                            if (w_head_last) begin
                                r_state <= StDone;
                                r_eof   <= 1'b1;
                            end else if (GAP > 0) begin
                                r_state   <= StGap;
                                r_gap_cnt <= GAP_LOAD;
                            end
                        end else begin
                            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                            if (w_head_last) begin
                                r_state <= StDone;
                                r_eof   <= 1'b1;
                            end
                        end
                    end
                end
                StIssue: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_issued_cnt != '1) r_issued_cnt <= r_issued_cnt + 1'b1;
                        if (r_cur_last) begin
                            r_state <= StDone;
                            r_eof   <= 1'b1;
                        end else if (GAP > 0) begin
                            r_state   <= StGap;
                            r_gap_cnt <= GAP_LOAD;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                StGap: begin
                    if (r_gap_cnt == '0) r_state <= StIdle;
                    else                 r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                StDone: begin
                    if (restart) begin
                        r_state      <= StIdle;
                        r_eof        <= 1'b0;
                        r_last_seen  <= 1'b0;
                        r_issued_cnt <= '0;
                        r_err_cnt    <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_sequencer.sv
// Self-checking bench for trace_sequencer: record table plus scoreboard of expected issues/pulses,
// with hand-written sequences for stalls, FIFO full, mid-run reset and restart.
module tb_trace_sequencer;

    localparam int DEPTH = 8;

    typedef enum int {KIssue, KClear, KPrint, KDrop} kind_e;
    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        last;
        kind_e       kind;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_cmd = '0;
    logic [31:0] in_addr = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_cmd;
    logic [31:0] out_addr;
    logic        clear_pls;
    logic        print_pls;
    logic        eof;
    logic        restart = 1'b0;
    logic [15:0] issued_cnt;
    logic [15:0] err_cnt;

    trace_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_addr    (in_addr),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cmd    (out_cmd),
        .out_addr   (out_addr),
        .clear_pls  (clear_pls),
        .print_pls  (print_pls),
        .eof        (eof),
        .restart    (restart),
        .issued_cnt (issued_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_err = 0;
    int   n_valid_seen = 0;
    int   n_clr_seen = 0;
    int   n_prt_seen = 0;
    rec_t sb[$];
    rec_t vecs[8];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void sb_pop(kind_e k);
        rec_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: got kind %0d expected nothing", k);
        end else begin
            e = sb.pop_front();
            chk("out_kind", 64'(k), 64'(e.kind));
            if (k == KIssue) begin
                chk("out_cmd", 64'(out_cmd), 64'(e.cmd));
                chk("out_addr", 64'(out_addr), 64'(e.addr));
            end
        end
    endfunction

    // Monitor on the falling edge; the bench drives inputs just after the rising edge.
    logic       prev_stall, prev_hs, prev_clr, prev_prt;
    logic [3:0] prev_cmd;
    logic [31:0] prev_addr;
    initial begin
        prev_stall = 1'b0; prev_hs = 1'b0; prev_clr = 1'b0; prev_prt = 1'b0;
        prev_cmd = '0; prev_addr = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_hs    <= 1'b0;
            prev_clr   <= 1'b0;
            prev_prt   <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_cmd", 64'(out_cmd), 64'(prev_cmd));
                chk("hold_addr", 64'(out_addr), 64'(prev_addr));
            end
            if (prev_hs)  chk("gap_after_issue", 64'(out_valid), 64'd0);
            if (prev_clr) chk("clear_width", 64'(clear_pls), 64'd0);
            if (prev_prt) chk("print_width", 64'(print_pls), 64'd0);
            if (out_valid && out_ready) sb_pop(KIssue);
            if (clear_pls) begin sb_pop(KClear); n_clr_seen++; end
            if (print_pls) begin sb_pop(KPrint); n_prt_seen++; end
            if (out_valid) n_valid_seen++;
            prev_stall <= out_valid && !out_ready;
            prev_hs    <= out_valid && out_ready;
            prev_clr   <= clear_pls;
            prev_prt   <= print_pls;
            prev_cmd   <= out_cmd;
            prev_addr  <= out_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input rec_t v);
        int n = 0;
        in_valid = 1'b1;
        in_cmd   = v.cmd;
        in_addr  = v.addr;
        in_last  = v.last;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready 0 expected 1 within 200 cycles");
        end else begin
            if (v.kind == KDrop) exp_err++;
            else                 sb.push_back(v);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_eof(input string nm);
        int n = 0;
        while (!eof && n < 300) begin
            tick();
            n++;
        end
        chk(nm, 64'(eof), 64'd1);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk(nm, 64'(out_valid), 64'd1);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_eof", 64'(eof), 64'd0);
        chk("restart_issued", 64'(issued_cnt), 64'd0);
        chk("restart_err", 64'(err_cnt), 64'd0);
        chk("restart_in_ready", 64'(in_ready), 64'd1);
        exp_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        rec_t r;
        int   v0;
        vecs[0] = '{4'h0, 32'h0000_0100, 1'b0, KIssue};
        vecs[1] = '{4'h1, 32'h0000_0200, 1'b1, KIssue};
        vecs[2] = '{4'h8, 32'h0000_0000, 1'b0, KClear};
        vecs[3] = '{4'h9, 32'h0000_0000, 1'b0, KPrint};
        vecs[4] = '{4'hC, 32'h0000_0000, 1'b1, KDrop};
        vecs[5] = '{4'h3, 32'h0000_0300, 1'b0, KIssue};
        vecs[6] = '{4'h7, 32'h0000_0700, 1'b0, KDrop};
        vecs[7] = '{4'h6, 32'h0000_0600, 1'b1, KIssue};

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_eof", 64'(eof), 64'd0);
        chk("rst_pulses", 64'({clear_pls, print_pls}), 64'd0);
        chk("rst_counts", 64'({issued_cnt, err_cnt}), 64'd0);
        rst = 1'b0;
        tick();

        // Two issues with a gap, then eof
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) push(vecs[i]);
        wait_eof("t1_eof");
        tick();
        chk("t1_issued", 64'(issued_cnt), 64'd2);
        chk("t1_err", 64'(err_cnt), 64'd0);
        chk("t1_done_in_ready", 64'(in_ready), 64'd0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        do_restart();

        // Stalled issue stays stable; restart is ignored outside DONE
        out_ready = 1'b0;
        r = '{4'h2, 32'h0000_ABCD, 1'b0, KIssue};
        push(r);
        wait_valid("t2_valid");
        restart = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            restart = 1'b0;
            chk("t2_valid_held", 64'(out_valid), 64'd1);
            chk("t2_cmd_held", 64'(out_cmd), 64'h2);
            chk("t2_addr_held", 64'(out_addr), 64'hABCD);
            chk("t2_no_count", 64'(issued_cnt), 64'd0);
        end
        chk("t2_restart_ignored", 64'(eof), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("t2_issued_once", 64'(issued_cnt), 64'd1);
        chk("t2_valid_drop", 64'(out_valid), 64'd0);
        tick();

        // Control pulses and an illegal last record
        v0 = n_valid_seen;
        for (int i = 2; i < 5; i++) push(vecs[i]);
        wait_eof("t3_eof");
        tick();
        chk("t3_err", 64'(err_cnt), 64'(exp_err));
        chk("t3_issued", 64'(issued_cnt), 64'd1);
        chk("t3_clr_seen", 64'(n_clr_seen), 64'd1);
        chk("t3_prt_seen", 64'(n_prt_seen), 64'd1);
        chk("t3_no_valid", 64'(n_valid_seen - v0), 64'd0);
        do_restart();

        // FIFO full while the head is stalled; extra record waits for a pop
        out_ready = 1'b0;
        r = '{4'h5, 32'h0000_0500, 1'b0, KIssue};
        push(r);
        wait_valid("t4_valid");
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_fill_ready", 64'(in_ready), 64'd1);
            r = '{4'(i % 7), 32'h1000 + 32'(i), 1'b0, KIssue};
            push(r);
        end
        chk("t4_full_block", 64'(in_ready), 64'd0);
        r = '{4'h4, 32'h0000_4444, 1'b1, KIssue};
        fork
            push(r);
            begin
                repeat (3) tick();
                chk("t4_still_full", 64'(in_ready), 64'd0);
                chk("t4_none_issued", 64'(issued_cnt), 64'd0);
                out_ready = 1'b1;
            end
        join
        wait_eof("t4_eof");
        tick();
        chk("t4_issued", 64'(issued_cnt), 64'(DEPTH + 2));
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Restart from DONE and run a fresh trace
        do_restart();
        for (int i = 5; i < 8; i++) push(vecs[i]);
        wait_eof("t6_eof");
        tick();
        chk("t6_issued", 64'(issued_cnt), 64'd2);
        chk("t6_err", 64'(err_cnt), 64'(exp_err));
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);
        do_restart();

        // Mid-run reset with one record on the bus and three buffered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = '{4'(i + 1), 32'h2000 + 32'(i), 1'b0, KIssue};
            push(r);
        end
        wait_valid("t5_valid");
        #2 rst = 1'b1;
        #1;
        chk("t5_valid_cleared", 64'(out_valid), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_outputs_zero",
            64'({clear_pls, print_pls, eof, out_cmd, out_addr, issued_cnt, err_cnt}), 64'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        v0 = n_valid_seen;
        repeat (20) tick();
        chk("t5_no_reissue", 64'(n_valid_seen - v0), 64'd0);
        chk("t5_issued_zero", 64'(issued_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
